// File: rtl/horiz_servo_pwm.sv
// Horizontal servo driver: frame-synchronous PWM, position stepping with end-stop clamping.
// Optional build macro HSERVO_STEP_DIV_EN: accept a step only once every STEP_DIV frames.
module horiz_servo_pwm #(
   parameter int unsigned FRAME_CYCLES = 2000000,
   parameter int unsigned PULSE_MIN    = 100000,
   parameter int unsigned PULSE_MAX    = 200000,
   parameter int unsigned PULSE_CENTER = 150000,
   parameter int unsigned STEP         = 1000,
   parameter int unsigned POS_W        = 18,
   parameter int unsigned STEP_DIV     = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CNT_L,
   input  logic             CNT_R,
   output logic             PWM,
   output logic             PWM_limit,
   output logic             PWM_limit_R,
   output logic [POS_W-1:0] POS
);

   localparam int unsigned FcntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [FcntW-1:0] FcntLast = FcntW'(FRAME_CYCLES - 1);
   localparam logic [POS_W-1:0] PosMin    = POS_W'(PULSE_MIN);
   localparam logic [POS_W-1:0] PosMax    = POS_W'(PULSE_MAX);
   localparam logic [POS_W-1:0] PosCenter = POS_W'(PULSE_CENTER);
   localparam logic [POS_W-1:0] PosStep   = POS_W'(STEP);
   localparam logic [POS_W:0]   MinExt    = (POS_W + 1)'(PULSE_MIN);
   localparam logic [POS_W:0]   MaxExt    = (POS_W + 1)'(PULSE_MAX);
   localparam logic [POS_W:0]   StepExt   = (POS_W + 1)'(STEP);

   logic [FcntW-1:0] fcnt_q, fcnt_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] pulse_q;
   logic             pwm_q;
   logic             limit_l_q, limit_r_q;
   logic             boundary;
   logic             step_en;
   logic [POS_W:0]   pos_ext, sum_ext;

   assign boundary = (fcnt_q == FcntLast);
   assign fcnt_d   = boundary ? '0 : fcnt_q + 1'b1;

`ifdef HSERVO_STEP_DIV_EN
   localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);
   logic [DivW-1:0] div_q;

   assign step_en = (div_q == DivLast);

   // Counts boundaries regardless of requests, so sweep rate stays fixed.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_q <= '0;
      end else if (boundary) begin
         div_q <= step_en ? '0 : div_q + 1'b1;
      end
   end
`else
   assign step_en = 1'b1;
`endif

   assign pos_ext = {1'b0, pos_q};
   assign sum_ext = pos_ext + StepExt;

   always_comb begin
      pos_d = pos_q;
      if (boundary && step_en) begin
         if (CNT_L && !CNT_R && (pos_q > PosMin)) begin
            // Compare before subtracting so the result can never wrap.
            pos_d = (pos_ext >= MinExt + StepExt) ? pos_q - PosStep : PosMin;
         end else if (CNT_R && !CNT_L && (pos_q < PosMax)) begin
            pos_d = (sum_ext > MaxExt) ? PosMax : sum_ext[POS_W-1:0];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         fcnt_q    <= '0;
         pos_q     <= PosCenter;
         pulse_q   <= PosCenter;
         pwm_q     <= 1'b0;
         limit_l_q <= 1'b1;
         limit_r_q <= 1'b1;
      end else begin
         fcnt_q    <= fcnt_d;
         pos_q     <= pos_d;
         // Latch the pre-step position so width is constant within a frame.
         if (boundary) begin
            pulse_q <= pos_q;
         end
         pwm_q     <= (32'(fcnt_q) < 32'(pulse_q));
         limit_l_q <= (pos_d > PosMin);
         limit_r_q <= (pos_d < PosMax);
      end
   end

   assign PWM         = pwm_q;
   assign PWM_limit   = limit_l_q;
   assign PWM_limit_R = limit_r_q;
   assign POS         = pos_q;

endmodule

// File: tb/tb_horiz_servo_pwm.sv
// Directed self-checking bench for horiz_servo_pwm with small frame parameters.
// Define HSERVO_STEP_DIV_EN on both files to exercise the step-divider build.
module tb_horiz_servo_pwm;

   localparam int unsigned FrameCycles = 100;

   logic       clk;
   logic       rst;
   logic       cnt_l;
   logic       cnt_r;
   logic       pwm;
   logic       pwm_limit;
   logic       pwm_limit_r;
   logic [7:0] pos;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int width;
   int first;

   horiz_servo_pwm #(
      .FRAME_CYCLES (100),
      .PULSE_MIN    (10),
      .PULSE_MAX    (20),
      .PULSE_CENTER (15),
      .STEP         (3),
      .POS_W        (8),
      .STEP_DIV     (4)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .CNT_L       (cnt_l),
      .CNT_R       (cnt_r),
      .PWM         (pwm),
      .PWM_limit   (pwm_limit),
      .PWM_limit_R (pwm_limit_r),
      .POS         (pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge; sample 1 time unit later. cyc tracks edges since reset release.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   // Runs one full frame starting just after a boundary edge.
   task automatic measure_frame(output int w, output int f);
      w = 0;
      f = -1;
      for (int i = 1; i <= FrameCycles; i++) begin
         tick();
         if (pwm) begin
            w++;
            if (f < 0) f = i;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      rst   = 1'b1;
      cnt_l = 1'b0;
      cnt_r = 1'b0;
      tick();
      tick();
      check_eq("reset_pwm", int'(pwm), 0);
      check_eq("reset_pos", int'(pos), 15);
      check_eq("reset_limit_l", int'(pwm_limit), 1);
      check_eq("reset_limit_r", int'(pwm_limit_r), 1);
      rst = 1'b0;
      cyc = 0;

`ifdef HSERVO_STEP_DIV_EN
      cnt_l = 1'b1;
      for (int b = 1; b <= 9; b++) begin
         run_to(b * FrameCycles);
         check_eq($sformatf("div_pos_b%0d", b), int'(pos), (b < 4) ? 15 : (b < 8) ? 12 : 10);
      end
      check_eq("div_limit_l", int'(pwm_limit), 0);
`else
      // Idle frame: width 15, rising one cycle after fcnt=0.
      measure_frame(width, first);
      check_eq("idle_width", width, 15);
      check_eq("idle_first", first, 1);
      check_eq("idle_pos", int'(pos), 15);

      // Step left to the end stop.
      cnt_l = 1'b1;
      measure_frame(width, first);
      check_eq("left_width_f1", width, 15);
      check_eq("left_pos_b2", int'(pos), 12);
      run_to(299);
      check_eq("left_pos_pre_b3", int'(pos), 12);
      check_eq("left_limit_pre_b3", int'(pwm_limit), 1);
      tick();
      check_eq("left_pos_b3", int'(pos), 10);
      check_eq("left_limit_b3", int'(pwm_limit), 0);
      check_eq("left_limit_r_b3", int'(pwm_limit_r), 1);
      measure_frame(width, first);
      check_eq("left_width_f3", width, 12);
      check_eq("left_pos_b4", int'(pos), 10);
      measure_frame(width, first);
      check_eq("left_width_f4", width, 10);
      check_eq("left_pos_b5", int'(pos), 10);

      // Step right to the end stop.
      cnt_l = 1'b0;
      cnt_r = 1'b1;
      run_to(600);
      check_eq("right_pos_b6", int'(pos), 13);
      check_eq("right_limit_b6", int'(pwm_limit), 1);
      run_to(700);
      check_eq("right_pos_b7", int'(pos), 16);
      run_to(800);
      check_eq("right_pos_b8", int'(pos), 19);
      check_eq("right_limit_r_b8", int'(pwm_limit_r), 1);
      run_to(900);
      check_eq("right_pos_b9", int'(pos), 20);
      check_eq("right_limit_r_b9", int'(pwm_limit_r), 0);
      run_to(1000);
      check_eq("right_pos_b10", int'(pos), 20);

      // Conflicting requests hold position.
      cnt_l = 1'b1;
      for (int b = 11; b <= 13; b++) begin
         run_to(b * FrameCycles);
         check_eq($sformatf("both_pos_b%0d", b), int'(pos), 20);
      end

      // Mid-frame request pulse is ignored.
      cnt_l = 1'b0;
      cnt_r = 1'b0;
      run_to(1350);
      cnt_l = 1'b1;
      tick();
      cnt_l = 1'b0;
      run_to(1400);
      check_eq("pulse_pos_b14", int'(pos), 20);

      // Reset mid-pulse at fcnt=7.
      run_to(1407);
      check_eq("midrst_pre_pwm", int'(pwm), 1);
      rst = 1'b1;
      tick();
      check_eq("midrst_pwm", int'(pwm), 0);
      check_eq("midrst_pos", int'(pos), 15);
      check_eq("midrst_limit_l", int'(pwm_limit), 1);
      check_eq("midrst_limit_r", int'(pwm_limit_r), 1);
      rst = 1'b0;
      cyc = 0;
      measure_frame(width, first);
      check_eq("postrst_width", width, 15);
      check_eq("postrst_first", first, 1);
      check_eq("postrst_pos", int'(pos), 15);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
